// File: rtl/led_7seg_scan.sv
// Multi-digit 7-segment scan controller with a double-buffered BCD word and per-slot blanking.
// Latency: seg/dig/frame_tick are registered one cycle behind the scan state; new words appear from the next frame boundary.
// Backpressure: load_ready is low while the shadow buffer holds an unapplied word and reopens the cycle after frame end.
module led_7seg_scan #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1024,
    parameter int BLANK    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*DIGITS-1:0]   load_bcd,
    input  logic [DIGITS-1:0]     load_dp,
    input  logic                  lz_en,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     dig,
    output logic                  frame_tick
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK);

    logic [DIV_W-1:0]    divCnt;
    logic [IDX_W-1:0]    digIdx;
    logic                frameEnd;

    logic [4*DIGITS-1:0] activeBcd;
    logic [DIGITS-1:0]   activeDp;
    logic [4*DIGITS-1:0] shadowBcd;
    logic [DIGITS-1:0]   shadowDp;
    logic                shadowFull;

    logic [DIGITS-1:0]   zeroFromHere;
    logic [3:0]          curNib;
    logic [7:0]          segNext;
    logic [DIGITS-1:0]   digNext;

    // Segment pattern for one nibble in {A,B,C,D,E,F,G} order; non-BCD values show a dash.
    function automatic logic [6:0] decodeNibble(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = 7'b1111110;
            4'd1:    pat = 7'b0110000;
            4'd2:    pat = 7'b1101101;
            4'd3:    pat = 7'b1111001;
            4'd4:    pat = 7'b0110011;
            4'd5:    pat = 7'b1011011;
            4'd6:    pat = 7'b1011111;
            4'd7:    pat = 7'b1110000;
            4'd8:    pat = 7'b1111111;
            4'd9:    pat = 7'b1111011;
            default: pat = 7'b0000001;
        endcase
        return pat;
    endfunction

    // Slot divider and digit index; the index steps once per completed slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            divCnt <= '0;
            digIdx <= '0;
        end else if (divCnt == DIV_LAST) begin
            divCnt <= '0;
            digIdx <= (digIdx == IDX_LAST) ? '0 : digIdx + 1'b1;
        end else begin
            divCnt <= divCnt + 1'b1;
        end
    end

    assign frameEnd   = (divCnt == DIV_LAST) && (digIdx == IDX_LAST);
    assign load_ready = ~shadowFull;

    // Shadow capture on handshake; promotion to active only at frame end so a frame never mixes words.
    // A handshake coinciding with frame end sees full=0, so that word waits for the following frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            activeBcd  <= '0;
            activeDp   <= '0;
            shadowBcd  <= '0;
            shadowDp   <= '0;
            shadowFull <= 1'b0;
        end else begin
            if (frameEnd && shadowFull) begin
                activeBcd  <= shadowBcd;
                activeDp   <= shadowDp;
                shadowFull <= 1'b0;
            end
            if (load_valid && !shadowFull) begin
                shadowBcd  <= load_bcd;
                shadowDp   <= load_dp;
                shadowFull <= 1'b1;
            end
        end
    end

    // zeroFromHere[i]: nibble i and every more-significant nibble are zero.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
        assign zeroFromHere[gi] = (activeBcd[4*DIGITS-1:4*gi] == '0);
    end

    // Next output pattern: dark during the blanking gap, otherwise the decoded selected digit.
    always_comb begin
        segNext = 8'h00;
        digNext = '0;
        curNib  = activeBcd[{digIdx, 2'b00} +: 4];
        if (divCnt >= BLANK_END) begin
            digNext[digIdx] = 1'b1;
            segNext         = {decodeNibble(curNib), activeDp[digIdx]};
            if (lz_en && (digIdx != '0) && zeroFromHere[digIdx]) begin
                segNext[7:1] = 7'd0;
            end
        end
    end

    // Registered pin drivers; frame_tick follows frame end by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg        <= 8'h00;
            dig        <= '0;
            frame_tick <= 1'b0;
        end else begin
            seg        <= segNext;
            dig        <= digNext;
            frame_tick <= frameEnd;
        end
    end

endmodule
